timer_bus_arbiter: RTL and testbench
====================================

# timer_bus_arbiter

Two-master round-robin arbiter that shares the single timer register port (req/gnt handshake) between master 0 (CPU) and master 1 (DMA). It sits between the masters and the timer slave. It serialises accesses and forwards address, write data and write enable from the owner. It returns the slave's gnt and rdata only to the owner, and guarantees a fresh rising edge on the slave `req` for every transaction.

## Interface
Parameters:
- P_ADDR_WIDTH, default from design_params_pkg: address width.
- P_DATA_WIDTH, default from design_params_pkg: data width.
- P_TIMEOUT, default 8: maximum cycles waited for the slave gnt (used only with the timeout feature).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- m0_req / m1_req, input, 1: master request; held high until that master's gnt.
- m0_addr / m1_addr, input, P_ADDR_WIDTH: master address; stable while req is high.
- m0_wdata / m1_wdata, input, P_DATA_WIDTH: master write data.
- m0_write_en / m1_write_en, input, 1: 1 = write, 0 = read.
- m0_gnt / m1_gnt, output, 1: one-cycle completion pulse to the owner.
- m0_rdata / m1_rdata, output, P_DATA_WIDTH: read data, valid in the gnt cycle.
- s_req, output, 1: request to the timer (registered).
- s_addr, output, P_ADDR_WIDTH: owner's address.
- s_wdata, output, P_DATA_WIDTH: owner's write data.
- s_write_en, output, 1: owner's write enable.
- s_gnt, input, 1: timer grant.
- s_rdata, input, P_DATA_WIDTH: timer read data.
- bus_err, output, 1: one-cycle timeout pulse.

## Operation
- FSM states: IDLE, WAIT, RELEASE.
- IDLE:
  - If any m*_req is sampled high, the arbiter picks a winner, registers `owner`, and goes to WAIT.
  - s_req is registered high on the same edge.
- Winner selection:
  - Single requester wins.
  - If both request, the master that was not `last` wins.
  - `last` resets to 1, so M0 wins the first tie.
- WAIT:
  - s_req = 1; s_addr, s_wdata and s_write_en are muxed from `owner`.
  - On s_gnt = 1: `owner`'s gnt = 1 combinationally in the same cycle, and its rdata = s_rdata.
  - Next edge: RELEASE, s_req = 0, `last` <= owner.
- RELEASE:
  - One cycle with s_req = 0, then IDLE.
  - This guarantees that s_req is low for at least 2 cycles between transactions.
- Non-owner outputs:
  - The non-owner's gnt is always 0.
  - m*_rdata = s_rdata when that master is owner, else 0.
- In IDLE and RELEASE, the s_addr, s_wdata and s_write_en muxes select `owner` (last value); values are don't-care while s_req = 0.
- s_gnt in IDLE or RELEASE is ignored and not forwarded.
- If the owner drops req while in WAIT (protocol violation), the transaction still completes and the gnt pulse is still delivered.
- A master that still holds req after its gnt is treated as a new request in the next IDLE.

## Timing
- Reset values: state = IDLE, owner = 0, last = 1, s_req = 0, m0_gnt = m1_gnt = 0, bus_err = 0, timeout counter = 0.
- Asserting reset mid-transaction aborts immediately; no gnt is issued.
- Latency:
  - m*_req sampled high at edge T0 gives s_req high from T0 to T1.
  - Master gnt coincides with s_gnt, so master-visible latency = slave latency + 1.
  - With the slave's 1–4 cycle grant window, master gnt arrives 2–5 cycles after the master req rise.
- Back-to-back minimum period per transaction: 1 (WAIT, best case) + RELEASE + IDLE cycles.
- Both masters requesting continuously get strict alternation: M0, M1, M0, …

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(P_TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without s_gnt.
  - When the count reaches P_TIMEOUT, for one cycle the arbiter drives the owner's gnt = 1, the owner's rdata = all ones, and bus_err = 1, then goes to RELEASE.
  - If s_gnt arrives in the same cycle, s_gnt wins: normal completion, bus_err = 0.
- ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely, the counter is absent, and bus_err is tied to 0.

## Test plan
- Single read: M0 requests addr 0x04, slave gnt after 2 cycles with s_rdata 0x1234 -> s_req rises 1 cycle after m0_req; m0_gnt pulses with m0_rdata = 0x1234; m1_gnt stays 0.
- Simultaneous requests after reset: M0 write 0xAA to 0x08 and M1 read 0x0C -> M0 is served first (s_wdata = 0xAA, s_write_en = 1), then s_req is low for 2 cycles, then M1 is served (s_addr = 0x0C).
- Fairness: both requests held for 6 transactions -> owner sequence 0,1,0,1,0,1; s_req gets a fresh rising edge each time.
- Reset mid-WAIT: assert reset while s_req = 1 -> s_req = 0 and the gnts are 0 asynchronously; after release, a pending M1 request is served normally.
- Timeout (ARB_TIMEOUT_EN, P_TIMEOUT = 8): slave never grants -> after 8 WAIT cycles, m1_gnt = 1, m1_rdata = all ones and bus_err = 1 for one cycle, then RELEASE.
- Late gnt on the timeout boundary: s_gnt arrives in the cycle the count reaches 8 -> normal completion with s_rdata forwarded and bus_err = 0.

Source files
------------

// File: rtl/timer_bus_arbiter.sv
// Two-master round-robin arbiter for the timer register port (CPU = m0, DMA = m1).
// Optional slave-grant timeout with bus_err pulse is enabled by defining ARB_TIMEOUT_EN.
package design_params_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
endpackage

module timer_bus_arbiter
  import design_params_pkg::*;
#(
  parameter int P_ADDR_WIDTH = ADDR_WIDTH,
  parameter int P_DATA_WIDTH = DATA_WIDTH,
  parameter int P_TIMEOUT    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic [P_ADDR_WIDTH-1:0] m0_addr,
  input  logic [P_DATA_WIDTH-1:0] m0_wdata,
  input  logic                    m0_write_en,
  output logic                    m0_gnt,
  output logic [P_DATA_WIDTH-1:0] m0_rdata,
  input  logic                    m1_req,
  input  logic [P_ADDR_WIDTH-1:0] m1_addr,
  input  logic [P_DATA_WIDTH-1:0] m1_wdata,
  input  logic                    m1_write_en,
  output logic                    m1_gnt,
  output logic [P_DATA_WIDTH-1:0] m1_rdata,
  output logic                    s_req,
  output logic [P_ADDR_WIDTH-1:0] s_addr,
  output logic [P_DATA_WIDTH-1:0] s_wdata,
  output logic                    s_write_en,
  input  logic                    s_gnt,
  input  logic [P_DATA_WIDTH-1:0] s_rdata,
  output logic                    bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  typedef struct packed {
    logic [P_ADDR_WIDTH-1:0] addr;
    logic [P_DATA_WIDTH-1:0] wdata;
    logic                    write_en;
  } mreq_t;

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   last, last_nx;
  logic   s_req_nx;
  logic   any_req, winner;
  logic   in_wait, timeout, done, err_cyc;
  mreq_t  req_sel;
  logic [P_DATA_WIDTH-1:0] rd_data;

  assign any_req = m0_req | m1_req;
  // On a tie the master that was not served last wins; last resets to 1 so m0 wins first.
  assign winner  = (m0_req & m1_req) ? ~last : m1_req;
  assign in_wait = (state == WAIT);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              to_cnt <= '0;
    else if (state == IDLE && any_req)      to_cnt <= '0;
    else if (in_wait && !s_gnt && !timeout) to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = in_wait && (to_cnt == CNT_W'(P_TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (P_TIMEOUT > 0);
  assign timeout        = 1'b0;
`endif

  // A real slave grant always beats a timeout landing in the same cycle.
  assign done    = in_wait & (s_gnt | timeout);
  assign err_cyc = in_wait & timeout & ~s_gnt;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    s_req_nx = s_req;
    case (state)
      IDLE: if (any_req) begin
        owner_nx = winner;
        state_nx = WAIT;
        s_req_nx = 1'b1;
      end
      WAIT: if (done) begin
        state_nx = RELEASE;
        s_req_nx = 1'b0;
        last_nx  = owner;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      s_req <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      s_req <= s_req_nx;
    end
  end

  assign req_sel    = owner ? mreq_t'{m1_addr, m1_wdata, m1_write_en}
                            : mreq_t'{m0_addr, m0_wdata, m0_write_en};
  assign s_addr     = req_sel.addr;
  assign s_wdata    = req_sel.wdata;
  assign s_write_en = req_sel.write_en;

  assign m0_gnt   = done & ~owner;
  assign m1_gnt   = done &  owner;
  assign rd_data  = err_cyc ? '1 : s_rdata;
  assign m0_rdata = owner ? '0 : rd_data;
  assign m1_rdata = owner ? rd_data : '0;
  assign bus_err  = err_cyc;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Randomized bench for timer_bus_arbiter against a transaction-level arbitration model.
module tb_timer_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    we;
  logic          m0_gnt, m1_gnt;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_write_en;
  logic          s_gnt;
  logic [DW-1:0] s_rdata;
  logic          bus_err;

  always #5 clk = ~clk;

  timer_bus_arbiter #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_write_en(we[0]),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_write_en(we[1]),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_write_en(s_write_en),
    .s_gnt(s_gnt), .s_rdata(s_rdata), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time, two idle cycles after each grant, alternate on ties.
  bit mbusy, mlast, mowner;
  int mcool;
  // Knobs
  bit model_en, rnd_en, hold, spur_en, no_gnt, rd_fix_en;
  int fixed_lat;
  logic [DW-1:0] rd_fix;
  // Slave and master bookkeeping
  int wcnt, lat;
  bit got [2];
  int wait_cyc [2];
  int ngnt [2];
  logic [DW-1:0] last_rd [2];
  int dut_served [$];

  task automatic new_req(input int i);
    req[i]   = 1'b1;
    addr[i]  = AW'($urandom);
    wdata[i] = DW'($urandom);
    we[i]    = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    mbusy = 0; mcool = 0; mlast = 1; mowner = 0; wcnt = 0;
    for (int i = 0; i < 2; i++) begin
      got[i] = 0; wait_cyc[i] = 0; ngnt[i] = 0;
    end
    dut_served.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; s_gnt = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic cycle();
    logic [1:0] g;
    @(posedge clk);
    if (model_en) begin
      if (mbusy) begin
        if (s_gnt) begin mbusy = 0; mlast = mowner; mcool = 1; end
      end else if (mcool > 0) mcool--;
      else if (req != 2'b00) begin
        mowner = (req == 2'b11) ? ~mlast : req[1];
        mbusy  = 1;
      end
    end
    #1;
    if (s_req) begin
      wcnt++;
      if (wcnt == 1) lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
    end else wcnt = 0;
    s_rdata = rd_fix_en ? rd_fix : DW'($urandom);
    if (s_req) s_gnt = !no_gnt && (wcnt == lat);
    else       s_gnt = spur_en && ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 2; i++) begin
      if (got[i]) begin
        got[i] = 0;
        if (hold || (rnd_en && $urandom_range(0, 2) == 0)) new_req(i);
        else req[i] = 1'b0;
      end else if (!req[i] && rnd_en && $urandom_range(0, 3) == 0) new_req(i);
    end
    @(negedge clk);
    if (model_en) begin
      g = {m1_gnt, m0_gnt};
      chk("s_req", s_req, mbusy);
      if (mbusy) begin
        chk("s_addr", s_addr, addr[mowner]);
        chk("s_wdata", s_wdata, wdata[mowner]);
        chk("s_write_en", s_write_en, we[mowner]);
      end
      chk("m0_gnt", m0_gnt, mbusy && s_gnt && !mowner);
      chk("m1_gnt", m1_gnt, mbusy && s_gnt && mowner);
      chk("m0_rdata", m0_rdata, mowner ? '0 : s_rdata);
      chk("m1_rdata", m1_rdata, mowner ? s_rdata : '0);
      chk("bus_err", bus_err, 0);
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          got[i] = 1; ngnt[i]++; wait_cyc[i] = 0;
          last_rd[i] = i ? m1_rdata : m0_rdata;
          dut_served.push_back(i);
        end else if (req[i]) wait_cyc[i]++;
        else wait_cyc[i] = 0;
        if (wait_cyc[i] == 30) chk("starve_bound", wait_cyc[i], 0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = '0; we = '0; s_gnt = 1'b0; s_rdata = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
    model_en = 0; rnd_en = 0; hold = 0; spur_en = 0; no_gnt = 0;
    rd_fix_en = 0; rd_fix = '0; fixed_lat = 0; lat = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req", s_req, 0);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 1'b0;

    // Single read from m0
    model_en = 1; fixed_lat = 2; rd_fix_en = 1; rd_fix = 16'h1234;
    req[0] = 1'b1; addr[0] = 8'h04; wdata[0] = '0; we[0] = 1'b0;
    for (int c = 0; c < 12 && ngnt[0] == 0; c++) cycle();
    repeat (4) cycle();
    chk("rd_m0_gnts", ngnt[0], 1);
    chk("rd_m0_rdata", last_rd[0], 16'h1234);
    chk("rd_m1_gnts", ngnt[1], 0);

    // Simultaneous requests held continuously: strict alternation from m0
    do_reset();
    rd_fix_en = 0; hold = 1;
    req = 2'b11;
    addr[0] = 8'h08; wdata[0] = 16'h00AA; we[0] = 1'b1;
    addr[1] = 8'h0C; wdata[1] = '0;       we[1] = 1'b0;
    for (int c = 0; c < 80 && dut_served.size() < 6; c++) cycle();
    chk("fair_count", dut_served.size(), 6);
    for (int i = 0; i < 6 && i < dut_served.size(); i++) chk("fair_seq", dut_served[i], i % 2);

    // Reset during WAIT aborts; pending m1 is served afterwards
    hold = 0; fixed_lat = 0;
    do_reset();
    no_gnt = 1;
    new_req(0);
    repeat (2) cycle();
    new_req(1);
    cycle();
    chk("mid_s_req_before", s_req, 1);
    #2 reset = 1'b1; s_gnt = 1'b1;
    #1;
    chk("mid_rst_s_req", s_req, 0);
    chk("mid_rst_m0_gnt", m0_gnt, 0);
    chk("mid_rst_m1_gnt", m1_gnt, 0);
    @(negedge clk);
    reset = 1'b0; s_gnt = 1'b0; req[0] = 1'b0; no_gnt = 0;
    model_reset();
    for (int c = 0; c < 20 && ngnt[1] == 0; c++) cycle();
    chk("mid_m1_served", ngnt[1], 1);
    chk("mid_m0_none", ngnt[0], 0);

    // Random traffic with spurious slave grants outside WAIT
    do_reset();
    rnd_en = 1; spur_en = 1;
    repeat (600) cycle();
    chk("rand_m0_served", ngnt[0] > 0, 1);
    chk("rand_m1_served", ngnt[1] > 0, 1);
    rnd_en = 0; spur_en = 0;
    repeat (20) cycle();

`ifdef ARB_TIMEOUT_EN
    // Slave never grants: timeout in the 9th WAIT cycle
    do_reset();
    model_en = 0; no_gnt = 1; fixed_lat = 0;
    new_req(1);
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 8) begin
        chk("to_pre_bus_err", bus_err, 0);
        chk("to_pre_m1_gnt", m1_gnt, 0);
      end
      if (c == 9) begin
        chk("to_m1_gnt", m1_gnt, 1);
        chk("to_m1_rdata", m1_rdata, 16'hFFFF);
        chk("to_bus_err", bus_err, 1);
        chk("to_m0_gnt", m0_gnt, 0);
        req[1] = 1'b0;
      end
      if (c == 10) begin
        chk("to_post_s_req", s_req, 0);
        chk("to_post_bus_err", bus_err, 0);
      end
    end

    // Slave grant lands exactly on the timeout boundary
    do_reset();
    no_gnt = 0; fixed_lat = 9; rd_fix_en = 1; rd_fix = 16'h5A5A;
    new_req(1);
    for (int c = 1; c <= 9; c++) cycle();
    chk("late_m1_gnt", m1_gnt, 1);
    chk("late_m1_rdata", m1_rdata, 16'h5A5A);
    chk("late_bus_err", bus_err, 0);
    req[1] = 1'b0;
    cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
